// File: rtl/hazard_ctrl_unit_if.sv
// hazard_ctrl_unit_if: ID-stage hazard request bundle and interlock responses.
// The master drives the ID/EX/halt requests; the slave (interlock unit) returns pipeline controls.
interface hazard_ctrl_unit_if #(
    parameter int REG_ADDR_W = 5,
    parameter int SEL_W = 3,
    parameter int CNT_W = 32
);
    logic [REG_ADDR_W-1:0] i_rs_addr, i_rt_addr, i_dst_addr;
    logic i_rs_used, i_rt_used, i_reg_write, i_mem_read, i_taken, i_halt_req, i_resume;
    logic o_pc_write, o_bubble_id_ex, o_flush_if_id, o_flush_id_ex, o_halted;
    logic [SEL_W-1:0] o_fwd_a, o_fwd_b;
    logic [CNT_W-1:0] o_stall_cnt, o_flush_cnt;
    modport master (
        output i_rs_addr, i_rs_used, i_rt_addr, i_rt_used, i_dst_addr, i_reg_write,
               i_mem_read, i_taken, i_halt_req, i_resume,
        input  o_pc_write, o_bubble_id_ex, o_flush_if_id, o_flush_id_ex, o_fwd_a, o_fwd_b,
               o_halted, o_stall_cnt, o_flush_cnt
    );
    modport slave (
        input  i_rs_addr, i_rs_used, i_rt_addr, i_rt_used, i_dst_addr, i_reg_write,
               i_mem_read, i_taken, i_halt_req, i_resume,
        output o_pc_write, o_bubble_id_ex, o_flush_if_id, o_flush_id_ex, o_fwd_a, o_fwd_b,
               o_halted, o_stall_cnt, o_flush_cnt
    );
endinterface

// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit: MIPS interlock - load-use stall, branch flush, forward select, drain/halt.
// Saturating stall/flush counters exist only when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int DEPTH = 3,
    parameter int LOAD_AVAIL = 2,
    parameter int SEL_W = 3,
    parameter int CNT_W = 32
) (
    input logic clk,
    input logic rst,
    hazard_ctrl_unit_if.slave bus
);
    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;
    localparam int DCW = $clog2(DEPTH + 1);
    state_t state_q, state_d;
    logic [DCW-1:0] drain_q, drain_d;
    logic [DEPTH:1] valid_q, valid_d, load_q, load_d;
    logic [DEPTH:1][REG_ADDR_W-1:0] dst_q, dst_d;
    logic [SEL_W-1:0] fwd_a, fwd_b;
    logic ld_a, ld_b, stall;
    logic pc_write, bubble, flush_if_id, flush_id_ex, halted;
    // Scan oldest to youngest so the youngest match wins; r0 never matches.
    always_comb begin
        fwd_a = '0;
        fwd_b = '0;
        ld_a = 1'b0;
        ld_b = 1'b0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (bus.i_rs_used && bus.i_rs_addr != '0 && valid_q[k] && dst_q[k] == bus.i_rs_addr) begin
                fwd_a = SEL_W'(k);
                ld_a = load_q[k] && k < LOAD_AVAIL;
            end
            if (bus.i_rt_used && bus.i_rt_addr != '0 && valid_q[k] && dst_q[k] == bus.i_rt_addr) begin
                fwd_b = SEL_W'(k);
                ld_b = load_q[k] && k < LOAD_AVAIL;
            end
        end
    end
    assign stall = ld_a || ld_b;
    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        pc_write = 1'b1;
        bubble = 1'b0;
        flush_if_id = 1'b0;
        flush_id_ex = 1'b0;
        halted = 1'b0;
        case (state_q)
            RUN: begin
                flush_if_id = bus.i_taken;
                flush_id_ex = bus.i_taken;
                bubble = stall && !bus.i_taken;
                pc_write = !bubble;
                if (bus.i_halt_req) begin
                    state_d = DRAIN;
                    drain_d = DCW'(DEPTH);
                end
            end
            DRAIN: begin
                pc_write = 1'b0;
                flush_if_id = 1'b1;
                bubble = 1'b1;
                drain_d = drain_q - DCW'(1);
                if (drain_q <= DCW'(1)) state_d = HALTED;
            end
            HALTED: begin
                pc_write = 1'b0;
                halted = 1'b1;
                if (bus.i_resume) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end
    // A taken branch kills both wrong-path slots: the ID instruction and the one leaving EX.
    always_comb begin
        valid_d = {valid_q[DEPTH-1:1], bus.i_reg_write && !bubble && !flush_id_ex};
        load_d = {load_q[DEPTH-1:1], bus.i_mem_read};
        dst_d = {dst_q[DEPTH-1:1], bus.i_dst_addr};
        valid_d[2] = valid_d[2] && !flush_id_ex;
        if (halted) valid_d = '0;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
            drain_q <= '0;
            valid_q <= '0;
            load_q <= '0;
            dst_q <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            valid_q <= valid_d;
            load_q <= load_d;
            dst_q <= dst_d;
        end
    end
`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
    always_comb begin
        stall_cnt_d = stall_cnt_q + CNT_W'(state_q == RUN && bubble && stall_cnt_q != '1);
        flush_cnt_d = flush_cnt_q + CNT_W'(state_q == RUN && bus.i_taken && flush_cnt_q != '1);
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end
    assign bus.o_stall_cnt = stall_cnt_q;
    assign bus.o_flush_cnt = flush_cnt_q;
`else
    assign bus.o_stall_cnt = '0;
    assign bus.o_flush_cnt = '0;
`endif
    assign bus.o_pc_write = pc_write;
    assign bus.o_bubble_id_ex = bubble;
    assign bus.o_flush_if_id = flush_if_id;
    assign bus.o_flush_id_ex = flush_id_ex;
    assign bus.o_halted = halted;
    assign bus.o_fwd_a = fwd_a;
    assign bus.o_fwd_b = fwd_b;
endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// tb_hazard_ctrl_unit: table of per-cycle ID vectors with expected interlock outputs,
// plus hand sequences for reset, drain/halt/resume and reset during drain.
module tb_hazard_ctrl_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    hazard_ctrl_unit_if #(.REG_ADDR_W(5), .SEL_W(3), .CNT_W(32)) bus();
    hazard_ctrl_unit dut (.clk(clk), .rst(rst), .bus(bus));
`ifdef HAZARD_PERF_CNT_EN
    localparam int PERF = 1;
`else
    localparam int PERF = 0;
`endif
    typedef struct {
        int rs, ru, rt, tu, dst, wr, ld, tk;
        int pcw, bub, fl, cf, fa, fb;
    } vec_t;
    vec_t tbl [19];
    int n_cmp = 0;
    int n_bad = 0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask
    task automatic set_id(input int rs, ru, rt, tu, dst, wr, ld, tk, hr, rsm);
        bus.i_rs_addr = 5'(rs);
        bus.i_rs_used = 1'(ru);
        bus.i_rt_addr = 5'(rt);
        bus.i_rt_used = 1'(tu);
        bus.i_dst_addr = 5'(dst);
        bus.i_reg_write = 1'(wr);
        bus.i_mem_read = 1'(ld);
        bus.i_taken = 1'(tk);
        bus.i_halt_req = 1'(hr);
        bus.i_resume = 1'(rsm);
    endtask
    task automatic chk_ctl(input string t, input int pcw, bub, fif, fie, hlt);
        chk({t, " pc_write"}, 32'(bus.o_pc_write), 32'(pcw));
        chk({t, " bubble"}, 32'(bus.o_bubble_id_ex), 32'(bub));
        chk({t, " flush_if_id"}, 32'(bus.o_flush_if_id), 32'(fif));
        chk({t, " flush_id_ex"}, 32'(bus.o_flush_id_ex), 32'(fie));
        chk({t, " halted"}, 32'(bus.o_halted), 32'(hlt));
    endtask
    task automatic chk_fwd(input string t, input int fa, fb);
        chk({t, " fwd_a"}, 32'(bus.o_fwd_a), 32'(fa));
        chk({t, " fwd_b"}, 32'(bus.o_fwd_b), 32'(fb));
    endtask
    task automatic chk_cnt(input string t, input int st, fl);
        chk({t, " stall_cnt"}, bus.o_stall_cnt, 32'(st));
        chk({t, " flush_cnt"}, bus.o_flush_cnt, 32'(fl));
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
    initial begin
        //           rs ru rt tu dst wr ld tk pcw bub fl cf fa fb
        tbl[0]  = '{5, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0};
        tbl[1]  = '{0, 0, 0, 0, 3, 1, 0, 0, 1, 0, 0, 1, 0, 0};
        tbl[2]  = '{3, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 0};
        tbl[3]  = '{3, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 2, 0};
        tbl[4]  = '{3, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 3, 0};
        tbl[5]  = '{3, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0};
        tbl[6]  = '{0, 0, 0, 0, 4, 1, 1, 0, 1, 0, 0, 1, 0, 0};
        tbl[7]  = '{0, 0, 4, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
        tbl[8]  = '{0, 0, 4, 1, 0, 0, 0, 0, 1, 0, 0, 1, 0, 2};
        tbl[9]  = '{0, 0, 4, 1, 0, 0, 0, 0, 1, 0, 0, 1, 0, 3};
        tbl[10] = '{0, 0, 0, 0, 6, 1, 1, 0, 1, 0, 0, 1, 0, 0};
        tbl[11] = '{6, 1, 0, 0, 0, 0, 0, 1, 1, 0, 1, 1, 1, 0};
        tbl[12] = '{6, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0};
        tbl[13] = '{0, 0, 0, 0, 7, 1, 0, 0, 1, 0, 0, 1, 0, 0};
        tbl[14] = '{0, 0, 0, 0, 9, 1, 0, 0, 1, 0, 0, 1, 0, 0};
        tbl[15] = '{0, 0, 0, 0, 7, 1, 0, 0, 1, 0, 0, 1, 0, 0};
        tbl[16] = '{7, 1, 9, 1, 0, 1, 1, 0, 1, 0, 0, 1, 1, 2};
        tbl[17] = '{0, 1, 7, 1, 0, 0, 0, 0, 1, 0, 0, 1, 0, 2};
        tbl[18] = '{7, 0, 7, 1, 0, 0, 0, 0, 1, 0, 0, 1, 0, 3};
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        #2 rst = 1'b0;
        #1;
        chk_ctl("reset", 1, 0, 0, 0, 0);
        chk_fwd("reset", 0, 0);
        chk_cnt("reset", 0, 0);
        tick();
        rst = 1'b1;
        foreach (tbl[i]) begin
            set_id(tbl[i].rs, tbl[i].ru, tbl[i].rt, tbl[i].tu, tbl[i].dst, tbl[i].wr, tbl[i].ld, tbl[i].tk, 0, 0);
            @(negedge clk);
            chk_ctl($sformatf("vec%0d", i), tbl[i].pcw, tbl[i].bub, tbl[i].fl, tbl[i].fl, 0);
            if (tbl[i].cf != 0) chk_fwd($sformatf("vec%0d", i), tbl[i].fa, tbl[i].fb);
            tick();
        end
        chk_cnt("after_table", PERF, PERF);
        set_id(2, 0, 0, 0, 2, 1, 0, 0, 1, 0);
        @(negedge clk);
        chk_ctl("halt_req", 1, 0, 0, 0, 0);
        tick();
        for (int c = 1; c <= 3; c++) begin
            set_id(0, 0, 0, 0, 0, 0, 0, int'(c == 1), 1, int'(c == 2));
            @(negedge clk);
            chk_ctl($sformatf("drain%0d", c), 0, 1, 1, 0, 0);
            tick();
        end
        set_id(2, 1, 0, 0, 2, 1, 0, 0, 1, 0);
        @(negedge clk);
        chk_ctl("halted", 0, 0, 0, 0, 1);
        chk_fwd("halted", 0, 0);
        tick();
        set_id(2, 1, 0, 0, 0, 0, 0, 0, 1, 1);
        @(negedge clk);
        chk_ctl("halted_hold", 0, 0, 0, 0, 1);
        chk_fwd("halted_hold", 0, 0);
        tick();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk_ctl("resumed", 1, 0, 0, 0, 0);
        chk_cnt("after_halt", PERF, PERF);
        tick();
        set_id(0, 0, 0, 0, 5, 1, 1, 0, 1, 0);
        tick();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        @(negedge clk);
        chk_ctl("pre_rst_drain", 0, 1, 1, 0, 0);
        #2 rst = 1'b0;
        #1;
        chk_ctl("rst_mid_drain", 1, 0, 0, 0, 0);
        chk_cnt("rst_mid_drain", 0, 0);
        tick();
        rst = 1'b1;
        set_id(5, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk_ctl("post_rst", 1, 0, 0, 0, 0);
        chk_fwd("post_rst", 0, 0);
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
